// File: rtl/iact_csc_encoder_pkg.sv
// Shared constants, FSM state encoding and the address-word helper for the
// iact CSC encoder.
package csc_pkg;

    localparam int               CSC_ADDR_W    = 7;
    localparam logic [6:0]       CSC_ZERO_CODE = 7'h7F;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ENCODE = 3'd1,
        TERM   = 3'd2,
        TERM2  = 3'd3,
        DONE   = 3'd4
    } csc_state_e;

    // A column that closes while no nonzero has been seen yet is marked with
    // ZERO_CODE, so an all-zero address word can only ever be a terminator.
    function automatic logic [CSC_ADDR_W-1:0] csc_addr_word(input logic [CSC_ADDR_W-1:0] nz);
        logic [CSC_ADDR_W-1:0] word;
        if (nz == 7'd0) begin
            word = CSC_ZERO_CODE;
        end else begin
            word = nz;
        end
        return word;
    endfunction

endpackage

// File: rtl/iact_csc_encoder_if.sv
// Handshake bundle between the dense iact source, the encoder and the two
// downstream GLB SRAMs (address and data).
interface iact_csc_encoder_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 4,
    parameter int ADDR_W = 7
);
    logic                    start;
    logic                    last_stream;
    logic                    in_valid;
    logic                    in_ready;
    logic [DATA_W-1:0]       in_data;
    logic                    addr_out_valid;
    logic                    addr_out_ready;
    logic [ADDR_W-1:0]       addr_out;
    logic                    data_out_valid;
    logic                    data_out_ready;
    logic [DATA_W+CNT_W-1:0] data_out;
    logic                    busy;
    logic                    done;

    modport master (
        output start, last_stream, in_valid, in_data, addr_out_ready, data_out_ready,
        input  in_ready, addr_out_valid, addr_out, data_out_valid, data_out, busy, done
    );

    modport slave (
        input  start, last_stream, in_valid, in_data, addr_out_ready, data_out_ready,
        output in_ready, addr_out_valid, addr_out, data_out_valid, data_out, busy, done
    );
endinterface

// File: rtl/iact_csc_encoder_csc_out_fifo.sv
// Small synchronous output FIFO. The head word is held in flops and shown
// directly on out_data; full/empty are registered from the next count.
module csc_out_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             full
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;
    logic             full_r;
    logic             empty_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Push/pop qualification and next occupancy; push+pop on full keeps the count.
    always_comb begin
        do_pop_s  = out_ready & ~empty_r;
        do_push_s = push & (~full_r | do_pop_s);
        case ({do_push_s, do_pop_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Storage, pointers and registered flags.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == CNT_W'(DEPTH));
            empty_r <= (count_nxt_s == {CNT_W{1'b0}});
        end
    end

    assign out_valid = ~empty_r;
    assign out_data  = mem_r[rd_ptr_r];
    assign full      = full_r;

endmodule

// File: rtl/iact_csc_encoder.sv
// Dense column-major iact stream -> CSC address and {value,row} data streams.
// Each stream ends in one all-zero terminator; the last stream of a set gets two.
module iact_csc_encoder
    import csc_pkg::*;
#(
    parameter int               MATRIX_H   = 9,
    parameter int               MATRIX_W   = 4,
    parameter int               DATA_W     = 8,
    parameter int               CNT_W      = 4,
    parameter int               ADDR_W     = CSC_ADDR_W,
    parameter logic [ADDR_W-1:0] ZERO_CODE = CSC_ZERO_CODE,
    parameter int               FIFO_DEPTH = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    iact_csc_encoder_if.slave  bus
);
    localparam int COL_W = (MATRIX_W > 1) ? $clog2(MATRIX_W) : 1;
    localparam int DW_W  = DATA_W + CNT_W;

    // Counts must never reach the ZERO_CODE marker and rows must fit CNT_W.
    generate
        if ((MATRIX_H * MATRIX_W) >= int'(ZERO_CODE) || (2 ** CNT_W) < MATRIX_H ||
            ADDR_W != CSC_ADDR_W || ZERO_CODE != CSC_ZERO_CODE || FIFO_DEPTH < 2) begin : g_bad_params
            $error("iact_csc_encoder: illegal parameter combination");
        end
    endgenerate

    csc_state_e         state_r;
    csc_state_e         state_nxt_s;
    logic [CNT_W-1:0]   row_r;
    logic [COL_W-1:0]   col_r;
    logic [ADDR_W-1:0]  nz_r;
    logic [ADDR_W-1:0]  nz_nxt_s;
    logic               last_r;
    logic               busy_r;
    logic               done_r;
    logic               addr_full_s;
    logic               data_full_s;
    logic               in_ready_s;
    logic               accept_s;
    logic               nonzero_s;
    logic               row_last_s;
    logic               col_last_s;
    logic               addr_push_s;
    logic [ADDR_W-1:0]  addr_word_s;
    logic               data_push_s;
    logic [DW_W-1:0]    data_word_s;

    // Accept gating: both FIFOs need room, so a paired push is always atomic.
    always_comb begin
        in_ready_s = (state_r == ENCODE) & ~addr_full_s & ~data_full_s;
        accept_s   = in_ready_s & bus.in_valid;
        nonzero_s  = (bus.in_data != {DATA_W{1'b0}});
        nz_nxt_s   = nz_r + ADDR_W'(nonzero_s);
        row_last_s = (row_r == CNT_W'(MATRIX_H - 1));
        col_last_s = (col_r == COL_W'(MATRIX_W - 1));
    end

    // Next-state and FIFO push decode.
    always_comb begin
        state_nxt_s = state_r;
        addr_push_s = 1'b0;
        addr_word_s = {ADDR_W{1'b0}};
        data_push_s = 1'b0;
        data_word_s = {DW_W{1'b0}};
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    state_nxt_s = ENCODE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ENCODE: begin
                if (accept_s) begin
                    data_push_s = nonzero_s;
                    data_word_s = {bus.in_data, row_r};
                    if (row_last_s) begin
                        addr_push_s = 1'b1;
                        addr_word_s = csc_addr_word(nz_nxt_s);
                        if (col_last_s) begin
                            state_nxt_s = TERM;
                        end else begin
                            state_nxt_s = ENCODE;
                        end
                    end else begin
                        state_nxt_s = ENCODE;
                    end
                end else begin
                    state_nxt_s = ENCODE;
                end
            end
            TERM, TERM2: begin
                if (~addr_full_s & ~data_full_s) begin
                    addr_push_s = 1'b1;
                    data_push_s = 1'b1;
                    if (state_r == TERM && last_r) begin
                        state_nxt_s = TERM2;
                    end else begin
                        state_nxt_s = DONE;
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register plus registered busy/done status.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != IDLE);
            done_r  <= (state_nxt_s == DONE);
        end
    end

    // Row/column/nonzero counters and the latched last_stream flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            row_r  <= {CNT_W{1'b0}};
            col_r  <= {COL_W{1'b0}};
            nz_r   <= {ADDR_W{1'b0}};
            last_r <= 1'b0;
        end else if (state_r == IDLE && bus.start) begin
            row_r  <= {CNT_W{1'b0}};
            col_r  <= {COL_W{1'b0}};
            nz_r   <= {ADDR_W{1'b0}};
            last_r <= bus.last_stream;
        end else if (accept_s) begin
            nz_r <= nz_nxt_s;
            if (row_last_s) begin
                row_r <= {CNT_W{1'b0}};
                col_r <= col_r + COL_W'(1);
            end else begin
                row_r <= row_r + CNT_W'(1);
            end
        end
    end

    csc_out_fifo #(.WIDTH(ADDR_W), .DEPTH(FIFO_DEPTH)) u_addr_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (addr_push_s),
        .push_data (addr_word_s),
        .out_ready (bus.addr_out_ready),
        .out_valid (bus.addr_out_valid),
        .out_data  (bus.addr_out),
        .full      (addr_full_s)
    );

    csc_out_fifo #(.WIDTH(DW_W), .DEPTH(FIFO_DEPTH)) u_data_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (data_push_s),
        .push_data (data_word_s),
        .out_ready (bus.data_out_ready),
        .out_valid (bus.data_out_valid),
        .out_data  (bus.data_out),
        .full      (data_full_s)
    );

    assign bus.in_ready = in_ready_s;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;

endmodule

// File: tb/tb_iact_csc_encoder.sv
// Directed and back-pressured checks of the iact CSC encoder on a 3x2 matrix.
module tb_iact_csc_encoder;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;
    localparam int ADDR_W = 7;
    localparam int H      = 3;
    localparam int W      = 2;
    localparam int N      = H * W;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    iact_csc_encoder_if #(.DATA_W(DATA_W), .CNT_W(CNT_W), .ADDR_W(ADDR_W)) bus ();

    iact_csc_encoder #(
        .MATRIX_H(H), .MATRIX_W(W), .DATA_W(DATA_W), .CNT_W(CNT_W), .ADDR_W(ADDR_W)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    typedef struct {
        logic              last;
        logic              mid;
        logic              rnd;
        logic [0:5][7:0]   e;
        int                na;
        logic [0:3][6:0]   a;
        int                nd;
        logic [0:7][11:0]  d;
    } vec_t;

    vec_t vecs[6];

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int acc_cnt = 0;
    logic [6:0]  got_a[$];
    logic [11:0] got_d[$];
    logic rnd_mode  = 1'b0;
    logic a_rdy_fix = 1'b1;
    logic d_rdy_fix = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Output monitor: a transfer seen here completes at the next rising edge.
    always @(negedge clock) begin
        if (reset_n) begin
            if (bus.addr_out_valid && bus.addr_out_ready) got_a.push_back(bus.addr_out);
            if (bus.data_out_valid && bus.data_out_ready) got_d.push_back(bus.data_out);
            if (bus.done) done_cnt++;
            if (bus.in_valid && bus.in_ready) acc_cnt++;
        end
    end

    // Downstream ready drivers: fixed or random back-pressure.
    always @(posedge clock) begin
        #1;
        if (rnd_mode) begin
            bus.addr_out_ready = 1'($urandom_range(0, 1));
            bus.data_out_ready = 1'($urandom_range(0, 1));
        end else begin
            bus.addr_out_ready = a_rdy_fix;
            bus.data_out_ready = d_rdy_fix;
        end
    end

    task automatic feed(input logic [7:0] val, input logic gaps);
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clock);
                #1;
            end
        end
        bus.in_valid = 1'b1;
        bus.in_data  = val;
        for (int t = 0; t < 300; t++) begin
            @(negedge clock);
            if (bus.in_ready) break;
            if (t == 299) chk("accept_timeout", 32'd0, 32'd1);
        end
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'd0;
    endtask

    task automatic pulse_start(input logic last);
        bus.start       = 1'b1;
        bus.last_stream = last;
        @(posedge clock);
        #1;
        bus.start       = 1'b0;
        bus.last_stream = 1'b0;
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 300; t++) begin
            @(negedge clock);
            if (!bus.busy) break;
            if (t == 299) chk("idle_timeout", 32'd0, 32'd1);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic run_stream(input vec_t v);
        pulse_start(v.last);
        for (int i = 0; i < N; i++) begin
            if (v.mid && i == 3) pulse_start(~v.last);
            feed(v.e[i], v.rnd);
        end
        wait_idle();
    endtask

    task automatic cmp_streams(input string tag, input logic [6:0] ea[$], input logic [11:0] ed[$],
                               input int exp_done);
        for (int t = 0; t < 300; t++) begin
            @(negedge clock);
            if (got_a.size() >= ea.size() && got_d.size() >= ed.size()) break;
            if (t == 299) chk({tag, "_drain_timeout"}, 32'd0, 32'd1);
        end
        repeat (4) @(posedge clock);
        #1;
        chk({tag, "_addr_count"}, 32'(got_a.size()), 32'(ea.size()));
        for (int i = 0; i < ea.size(); i++)
            if (i < got_a.size()) chk($sformatf("%s_addr%0d", tag, i), 32'(got_a[i]), 32'(ea[i]));
        chk({tag, "_data_count"}, 32'(got_d.size()), 32'(ed.size()));
        for (int i = 0; i < ed.size(); i++)
            if (i < got_d.size()) chk($sformatf("%s_data%0d", tag, i), 32'(got_d[i]), 32'(ed[i]));
        chk({tag, "_done_pulses"}, 32'(done_cnt), 32'(exp_done));
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        logic [6:0]  ea[$];
        logic [11:0] ed[$];
        got_a.delete();
        got_d.delete();
        done_cnt = 0;
        rnd_mode = v.rnd;
        run_stream(v);
        rnd_mode = 1'b0;
        for (int i = 0; i < v.na; i++) ea.push_back(v.a[i]);
        for (int i = 0; i < v.nd; i++) ed.push_back(v.d[i]);
        cmp_streams(tag, ea, ed, 1);
    endtask

    initial begin
        vec_t        rv;
        logic [6:0]  ea[$];
        logic [11:0] ed[$];
        int          nz;

        bus.start = 1'b0; bus.last_stream = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'd0;

        // case 1: 5,0,7 | 0,0,2
        vecs[0] = '{last: 1'b0, mid: 1'b0, rnd: 1'b0,
                    e: {8'd5, 8'd0, 8'd7, 8'd0, 8'd0, 8'd2},
                    na: 3, a: {7'h02, 7'h03, 7'h00, 7'h00},
                    nd: 4, d: {12'h050, 12'h072, 12'h022, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000}};
        // case 2: 0,0,0 | 0,4,0 final stream
        vecs[1] = '{last: 1'b1, mid: 1'b0, rnd: 1'b0,
                    e: {8'd0, 8'd0, 8'd0, 8'd0, 8'd4, 8'd0},
                    na: 4, a: {7'h7F, 7'h01, 7'h00, 7'h00},
                    nd: 3, d: {12'h041, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000}};
        // case 4: all zero, final stream
        vecs[2] = '{last: 1'b1, mid: 1'b0, rnd: 1'b0,
                    e: {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0},
                    na: 4, a: {7'h7F, 7'h7F, 7'h00, 7'h00},
                    nd: 2, d: {12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000}};
        // fully dense, more words than one FIFO holds
        vecs[3] = '{last: 1'b0, mid: 1'b0, rnd: 1'b0,
                    e: {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6},
                    na: 3, a: {7'h03, 7'h06, 7'h00, 7'h00},
                    nd: 7, d: {12'h010, 12'h021, 12'h032, 12'h040, 12'h051, 12'h062, 12'h000, 12'h000}};
        // case 6: start pulsed (with last_stream=1) mid-stream must be ignored
        vecs[4] = vecs[0];
        vecs[4].mid = 1'b1;
        // dense final stream under random gaps and back-pressure
        vecs[5] = '{last: 1'b1, mid: 1'b0, rnd: 1'b1,
                    e: {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6},
                    na: 4, a: {7'h03, 7'h06, 7'h00, 7'h00},
                    nd: 8, d: {12'h010, 12'h021, 12'h032, 12'h040, 12'h051, 12'h062, 12'h000, 12'h000}};

        // reset state
        #12;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_addr_valid", 32'(bus.addr_out_valid), 32'd0);
        chk("rst_data_valid", 32'(bus.data_out_valid), 32'd0);
        chk("rst_addr_out", 32'(bus.addr_out), 32'd0);
        chk("rst_data_out", 32'(bus.data_out), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        for (int v = 0; v < 6; v++) run_vec($sformatf("vec%0d", v), vecs[v]);

        // case 3: address SRAM stalled across two back-to-back streams
        got_a.delete();
        got_d.delete();
        done_cnt  = 0;
        acc_cnt   = 0;
        a_rdy_fix = 1'b0;
        fork
            begin
                run_stream(vecs[0]);
                run_stream(vecs[0]);
            end
            begin
                repeat (40) @(negedge clock);
                chk("stall_accepts", 32'(acc_cnt), 32'd9);
                chk("stall_in_valid", 32'(bus.in_valid), 32'd1);
                chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
                chk("stall_addr_words", 32'(got_a.size()), 32'd0);
                chk("stall_data_words", 32'(got_d.size()), 32'd6);
                @(posedge clock);
                #1;
                a_rdy_fix = 1'b1;
            end
        join
        ea = '{7'h02, 7'h03, 7'h00, 7'h02, 7'h03, 7'h00};
        ed = '{12'h050, 12'h072, 12'h022, 12'h000, 12'h050, 12'h072, 12'h022, 12'h000};
        cmp_streams("stall", ea, ed, 2);

        // case 5: asynchronous reset after three accepted elements
        got_a.delete();
        got_d.delete();
        pulse_start(1'b0);
        feed(8'd5, 1'b0);
        feed(8'd0, 1'b0);
        feed(8'd7, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_addr_valid", 32'(bus.addr_out_valid), 32'd0);
        chk("mid_rst_data_valid", 32'(bus.data_out_valid), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        run_vec("after_rst", vecs[1]);

        // random matrices and back-pressure against a reference model
        for (int k = 0; k < 4; k++) begin
            rv = vecs[0];
            rv.last = 1'($urandom_range(0, 1));
            rv.rnd  = 1'b1;
            for (int i = 0; i < N; i++) rv.e[i] = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 255)) : 8'd0;
            ea.delete();
            ed.delete();
            nz = 0;
            for (int c = 0; c < W; c++) begin
                for (int r = 0; r < H; r++) begin
                    if (rv.e[c * H + r] != 8'd0) begin
                        ed.push_back({rv.e[c * H + r], 4'(r)});
                        nz++;
                    end
                end
                ea.push_back((nz == 0) ? 7'h7F : 7'(nz));
            end
            ea.push_back(7'h00);
            ed.push_back(12'h000);
            if (rv.last) begin
                ea.push_back(7'h00);
                ed.push_back(12'h000);
            end
            got_a.delete();
            got_d.delete();
            done_cnt = 0;
            rnd_mode = 1'b1;
            run_stream(rv);
            rnd_mode = 1'b0;
            cmp_streams($sformatf("rand%0d", k), ea, ed, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
